mips_cpu: RTL and testbench
===========================

MIPS_CPU -- requirements
Module: mips_cpu

Interface
REQ-001 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit, synchronous active-high reset; it also enables program/data loading.
REQ-003 The module SHALL have port inst_data, input, 32 bits, the word to load into instruction or data memory.
REQ-004 The module SHALL have port address, input, 10 bits, the load address.
REQ-005 The module SHALL have port write_instruction, input, 1 bit, which writes inst_data to instruction memory[address].
REQ-006 The module SHALL have port write_data, input, 1 bit, which writes inst_data to data memory[address].
REQ-007 The module SHALL have ports OutputOfR1..OutputOfR5, outputs, 32 bits each, giving the combinational value of registers 1..5.

Function
REQ-008 The design SHALL contain a 10-bit PC, 32x32 register file, 1024x32 instruction memory and 1024x32 data memory (word-addressed).
REQ-009 Both memories SHALL power up to all zeros and SHALL NOT be cleared by rst.
REQ-010 Register 0 SHALL read as 0 always; writes to it are discarded.
REQ-011 Instruction format SHALL be: opcode[31:26], A[25:21], B[20:16], imm[15:0]; simm = sign-extended imm.
REQ-012 While rst=0, execution SHALL be single-cycle: fetch instr_mem[PC], execute, and update the PC/register/memory on the same edge.
REQ-013 ADDI, opcode 000001: R[A] <= R[B] + simm (mod 2^32); PC <= PC+1.
REQ-014 LW, opcode 000111: R[A] <= dmem[(R[B]+simm)[9:0]]; PC <= PC+1.
REQ-015 SW, opcode 001000: dmem[(R[B]+simm)[9:0]] <= R[A]; PC <= PC+1.
REQ-016 BEQ, opcode 010000: if R[A]==R[B] then PC <= PC+1+simm[9:0], else PC+1.
REQ-017 BGE, opcode 010101: if signed R[A] >= signed R[B] then PC <= PC+1+simm[9:0], else PC+1.
REQ-018 HALT, opcode 000000: PC holds and no state changes; unwritten instruction memory therefore halts.
REQ-019 Any other opcode SHALL be a NOP (PC <= PC+1).
REQ-020 PC arithmetic SHALL wrap modulo 1024.
REQ-021 Load writes SHALL be honoured only while rst=1.
REQ-022 write_instruction and write_data asserted together SHALL write both memories at the same address.
REQ-023 With rst=0, write_instruction and write_data SHALL be ignored.

Reset
REQ-024 On a clock edge with rst=1: PC <= 0, registers 1..31 <= 0, so OutputOfR1..R5 = 0.
REQ-025 Asserting rst mid-program SHALL abort execution at that edge; execution restarts at PC 0 on the first edge after rst falls.

Configuration
REQ-026 Macro MIPS_CPU_BGE_EN: when defined, opcode 010101 SHALL execute as BGE; when undefined, 010101 SHALL be a NOP and no comparator logic is built.

Verification
REQ-027 Insertion sort: load dmem[0..4] = 7,12,9,11,3 and the 20-word sort program (addi/beq/lw/bge/sw, ending with lw R1..R5 from dmem[0..4]), release rst, wait 100 cycles -> OutputOfR1..R5 = 3,7,9,11,12 and PC halted at 20.
REQ-028 ADDI sign-extension: addi $1,$0,5 then addi $2,$1,0xFFFF -> R1=5, R2=4.
REQ-029 Branch offsets: beq $0,$0,-1 at PC 3 -> PC stays 3; bge with R[A]=-1, R[B]=0 -> not taken (PC+1).
REQ-030 Load gating: pulse write_data with address=7, inst_data=99 while rst=0 -> dmem[7] unchanged; the same pulse during rst=1 -> dmem[7]=99.
REQ-031 Reset mid-run: assert rst for one edge while R1..R5 are nonzero -> outputs read 0 and PC=0; memories retain their contents.

Source files
------------

// File: rtl/mips_cpu.sv
// rtl/mips_cpu.sv - single-cycle MIPS-like CPU with loadable instruction/data memories
//
// Purpose: executes ADDI/LW/SW/BEQ/(BGE)/HALT from a word-addressed 1024x32
// instruction memory against a 32x32 register file and 1024x32 data memory.
// While rst is high the core is held at PC 0 with registers cleared, and the
// memories may be loaded through the load port.
//
// Ports:
//   clk                  single clock, rising edge
//   rst                  synchronous active-high reset; also the load-enable window
//   inst_data[31:0]      word to load
//   address[9:0]         load address
//   write_instruction    load inst_data into instruction memory (rst=1 only)
//   write_data           load inst_data into data memory (rst=1 only)
//   OutputOfR1..R5       combinational view of registers 1..5
//
// Configuration: define MIPS_CPU_BGE_EN to build the signed BGE instruction
// (opcode 010101); without it that opcode decodes as a NOP.
module mips_cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_data,
  input  logic [9:0]  address,
  input  logic        write_instruction,
  input  logic        write_data,
  output logic [31:0] OutputOfR1,
  output logic [31:0] OutputOfR2,
  output logic [31:0] OutputOfR3,
  output logic [31:0] OutputOfR4,
  output logic [31:0] OutputOfR5
);

  localparam logic [5:0] OP_HALT = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000111;
  localparam logic [5:0] OP_SW   = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b010000;
`ifdef MIPS_CPU_BGE_EN
  localparam logic [5:0] OP_BGE  = 6'b010101;
`endif

  logic [9:0]  pc;
  logic [9:0]  pc_inc;
  logic [9:0]  pc_tgt;
  logic [9:0]  pc_next;
  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:1023];
  logic [31:0] regs [0:31];

  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [15:0] imm;
  logic [31:0] simm;
  logic [31:0] val_a;
  logic [31:0] val_b;
  logic [9:0]  mem_addr;
  logic        reg_we;
  logic        mem_we;
  logic [31:0] reg_wd;

  assign instr  = imem[pc];
  assign opcode = instr[31:26];
  assign ra     = instr[25:21];
  assign rb     = instr[20:16];
  assign imm    = instr[15:0];
  assign simm   = {{16{imm[15]}}, imm};

  // Register 0 is hard-wired to zero on the read side; its storage is never used.
  assign val_a = (ra == 5'd0) ? 32'd0 : regs[ra];
  assign val_b = (rb == 5'd0) ? 32'd0 : regs[rb];

  // Only the low 10 bits of the effective address matter, so add just those.
  assign mem_addr = val_b[9:0] + simm[9:0];
  assign pc_inc   = pc + 10'd1;
  assign pc_tgt   = pc_inc + imm[9:0];

`ifdef MIPS_CPU_BGE_EN
  logic bge_taken;
  assign bge_taken = $signed(val_a) >= $signed(val_b);
`endif

  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    reg_wd  = val_b + simm;
    pc_next = pc_inc;
    case (opcode)
      OP_HALT: pc_next = pc;
      OP_ADDI: reg_we = 1'b1;
      OP_LW: begin
        reg_we = 1'b1;
        reg_wd = dmem[mem_addr];
      end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (val_a == val_b) pc_next = pc_tgt;
`ifdef MIPS_CPU_BGE_EN
      OP_BGE:  if (bge_taken) pc_next = pc_tgt;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= 10'd0;
    else     pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (reg_we && (ra != 5'd0)) begin
      regs[ra] <= reg_wd;
    end
  end

  // Memories have no reset: their contents survive rst so a program can be
  // loaded under reset and then run.
  always_ff @(posedge clk) begin
    if (rst && write_instruction) imem[address] <= inst_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (write_data) dmem[address] <= inst_data;
    end else if (mem_we) begin
      dmem[mem_addr] <= val_a;
    end
  end

  assign OutputOfR1 = regs[1];
  assign OutputOfR2 = regs[2];
  assign OutputOfR3 = regs[3];
  assign OutputOfR4 = regs[4];
  assign OutputOfR5 = regs[5];

endmodule

// File: tb/tb_mips_cpu.sv
// tb/tb_mips_cpu.sv - self-checking scoreboard bench for mips_cpu
module tb_mips_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_data = 32'd0;
  logic [9:0]  address = 10'd0;
  logic        write_instruction = 1'b0;
  logic        write_data = 1'b0;
  logic [31:0] r1, r2, r3, r4, r5;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] prog [0:31];
  int prog_len;

  localparam logic [5:0] ADDI = 6'b000001;
  localparam logic [5:0] LW   = 6'b000111;
  localparam logic [5:0] SW   = 6'b001000;
  localparam logic [5:0] BEQ  = 6'b010000;
  localparam logic [5:0] BGE  = 6'b010101;
  localparam logic [5:0] NOP  = 6'b111111;

  mips_cpu dut (
    .clk(clk), .rst(rst), .inst_data(inst_data), .address(address),
    .write_instruction(write_instruction), .write_data(write_data),
    .OutputOfR1(r1), .OutputOfR2(r2), .OutputOfR3(r3), .OutputOfR4(r4), .OutputOfR5(r5)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [31:0] rout(input int k);
    case (k)
      1: return r1;
      2: return r2;
      3: return r3;
      4: return r4;
      default: return r5;
    endcase
  endfunction

  task automatic load(input logic wi, input logic wd, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = 1'b1; write_instruction = wi; write_data = wd; address = a; inst_data = d;
    @(posedge clk); #1;
    write_instruction = 1'b0; write_data = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog_len; i++) load(1'b1, 1'b0, 10'(i), prog[i]);
    load(1'b1, 1'b0, 10'(prog_len), 32'd0);
  endtask

  task automatic run(input int n);
    @(negedge clk);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    @(negedge clk); rst = 1'b1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(32'd0);
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      e = exp_q.pop_front(); n_vec++;
      if (rout(k) !== e) begin n_err++; $display("FAIL reset_r%0d: got %h expected %h", k, rout(k), e); end
    end
    n_vec++;
    if (dut.pc !== 10'd0) begin n_err++; $display("FAIL reset_pc: got %0d expected 0", dut.pc); end
  endtask

  task automatic test_sort();
    logic [31:0] e;
    load(1'b0, 1'b1, 10'd0, 32'd7);
    load(1'b0, 1'b1, 10'd1, 32'd12);
    load(1'b0, 1'b1, 10'd2, 32'd9);
    load(1'b0, 1'b1, 10'd3, 32'd11);
    load(1'b0, 1'b1, 10'd4, 32'd3);
    prog[0]  = enc(ADDI, 1, 0, 16'd1);
    prog[1]  = enc(ADDI, 5, 0, 16'd5);
    prog[2]  = enc(BEQ,  1, 5, 16'd11);
    prog[3]  = enc(LW,   3, 1, 16'd0);
    prog[4]  = enc(ADDI, 2, 1, 16'd0);
    prog[5]  = enc(BEQ,  2, 0, 16'd5);
    prog[6]  = enc(LW,   4, 2, 16'hFFFF);
    prog[7]  = enc(BGE,  3, 4, 16'd3);
    prog[8]  = enc(SW,   4, 2, 16'd0);
    prog[9]  = enc(ADDI, 2, 2, 16'hFFFF);
    prog[10] = enc(BEQ,  0, 0, 16'hFFFA);
    prog[11] = enc(SW,   3, 2, 16'd0);
    prog[12] = enc(ADDI, 1, 1, 16'd1);
    prog[13] = enc(BEQ,  0, 0, 16'hFFF4);
    prog[14] = enc(ADDI, 0, 0, 16'd7);
    for (int k = 1; k <= 5; k++) prog[14+k] = enc(LW, 5'(k), 0, 16'(k-1));
    prog_len = 20;
    load_prog();
`ifdef MIPS_CPU_BGE_EN
    exp_q.push_back(32'd3); exp_q.push_back(32'd7); exp_q.push_back(32'd9);
    exp_q.push_back(32'd11); exp_q.push_back(32'd12);
`else
    // Without BGE every key is shifted all the way down to slot 0.
    exp_q.push_back(32'd3); exp_q.push_back(32'd11); exp_q.push_back(32'd9);
    exp_q.push_back(32'd12); exp_q.push_back(32'd7);
`endif
    run(100);
    for (int k = 1; k <= 5; k++) begin
      e = exp_q.pop_front(); n_vec++;
      if (rout(k) !== e) begin n_err++; $display("FAIL sort_r%0d: got %0d expected %0d", k, rout(k), e); end
    end
    n_vec++;
    if (dut.pc !== 10'd20) begin n_err++; $display("FAIL sort_pc: got %0d expected 20", dut.pc); end
  endtask

  task automatic test_addi_sext();
    logic [31:0] e;
    prog[0] = enc(ADDI, 1, 0, 16'd5);
    prog[1] = enc(ADDI, 2, 1, 16'hFFFF);
    prog[2] = enc(ADDI, 0, 0, 16'd9);
    prog[3] = enc(ADDI, 3, 0, 16'd0);
    prog_len = 4;
    load_prog();
    exp_q.push_back(32'd5); exp_q.push_back(32'd4); exp_q.push_back(32'd0);
    run(6);
    for (int k = 1; k <= 3; k++) begin
      e = exp_q.pop_front(); n_vec++;
      if (rout(k) !== e) begin n_err++; $display("FAIL addi_r%0d: got %h expected %h", k, rout(k), e); end
    end
    n_vec++;
    if (dut.pc !== 10'd4) begin n_err++; $display("FAIL addi_pc: got %0d expected 4", dut.pc); end
  endtask

  task automatic test_load_store();
    logic [31:0] e;
    load(1'b0, 1'b1, 10'd1023, 32'h0000_1234);
    prog[0] = enc(ADDI, 1, 0, 16'd42);
    prog[1] = enc(SW,   1, 0, 16'd100);
    prog[2] = enc(LW,   2, 0, 16'd100);
    prog[3] = enc(LW,   3, 0, 16'hFFFF);
    prog_len = 4;
    load_prog();
    exp_q.push_back(32'd42); exp_q.push_back(32'd42); exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'd42);
    run(6);
    for (int k = 1; k <= 3; k++) begin
      e = exp_q.pop_front(); n_vec++;
      if (rout(k) !== e) begin n_err++; $display("FAIL ldst_r%0d: got %h expected %h", k, rout(k), e); end
    end
    e = exp_q.pop_front(); n_vec++;
    if (dut.dmem[100] !== e) begin n_err++; $display("FAIL sw_dmem100: got %h expected %h", dut.dmem[100], e); end
  endtask

  task automatic test_branch();
    logic [31:0] e;
    prog[0] = enc(ADDI, 1, 0, 16'hFFFF);
    prog[1] = enc(BGE,  1, 0, 16'd5);
    prog[2] = enc(NOP,  0, 0, 16'd0);
    prog[3] = enc(BEQ,  0, 0, 16'hFFFF);
    prog_len = 4;
    load_prog();
    exp_q.push_back(32'hFFFF_FFFF);
    run(2);
    n_vec++;
    if (dut.pc !== 10'd2) begin n_err++; $display("FAIL bge_not_taken_pc: got %0d expected 2", dut.pc); end
    run(6);
    n_vec++;
    if (dut.pc !== 10'd3) begin n_err++; $display("FAIL beq_self_pc: got %0d expected 3", dut.pc); end
    e = exp_q.pop_front(); n_vec++;
    if (r1 !== e) begin n_err++; $display("FAIL branch_r1: got %h expected %h", r1, e); end

    prog[0] = enc(ADDI, 1, 0, 16'hFFFF);
    prog[1] = enc(BGE,  0, 1, 16'd4);
    prog_len = 2;
    load_prog();
    load(1'b1, 1'b0, 10'd6, 32'd0);
    run(2);
    n_vec++;
`ifdef MIPS_CPU_BGE_EN
    if (dut.pc !== 10'd6) begin n_err++; $display("FAIL bge_taken_pc: got %0d expected 6", dut.pc); end
`else
    if (dut.pc !== 10'd2) begin n_err++; $display("FAIL bge_nop_pc: got %0d expected 2", dut.pc); end
`endif

    prog[0] = enc(NOP, 0, 0, 16'd0);
    prog[1] = enc(NOP, 0, 0, 16'd0);
    prog[2] = enc(BEQ, 0, 0, 16'hFFFB);
    prog_len = 3;
    load_prog();
    load(1'b1, 1'b0, 10'd1022, 32'd0);
    run(5);
    n_vec++;
    if (dut.pc !== 10'd1022) begin n_err++; $display("FAIL pc_wrap: got %0d expected 1022", dut.pc); end
  endtask

  task automatic test_load_gating();
    load(1'b0, 1'b1, 10'd7, 32'd5);
    load(1'b1, 1'b0, 10'd7, 32'hCAFE_0007);
    load(1'b1, 1'b0, 10'd0, 32'd0);
    run(2);
    @(negedge clk);
    write_data = 1'b1; write_instruction = 1'b1; address = 10'd7; inst_data = 32'd99;
    @(posedge clk); #1;
    write_data = 1'b0; write_instruction = 1'b0;
    n_vec++;
    if (dut.dmem[7] !== 32'd5) begin n_err++; $display("FAIL gate_dmem7: got %0d expected 5", dut.dmem[7]); end
    n_vec++;
    if (dut.imem[7] !== 32'hCAFE_0007) begin n_err++; $display("FAIL gate_imem7: got %h expected cafe0007", dut.imem[7]); end
    load(1'b1, 1'b1, 10'd7, 32'd99);
    n_vec++;
    if (dut.dmem[7] !== 32'd99) begin n_err++; $display("FAIL load_dmem7: got %0d expected 99", dut.dmem[7]); end
    n_vec++;
    if (dut.imem[7] !== 32'd99) begin n_err++; $display("FAIL load_imem7: got %0d expected 99", dut.imem[7]); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] e;
    load(1'b0, 1'b1, 10'd200, 32'h0000_ABCD);
    for (int k = 1; k <= 5; k++) prog[k-1] = enc(ADDI, 5'(k), 0, 16'(k + 10));
    prog[5] = enc(BEQ, 0, 0, 16'hFFFF);
    prog_len = 6;
    load_prog();
    for (int k = 1; k <= 5; k++) exp_q.push_back(32'(k + 10));
    run(8);
    for (int k = 1; k <= 5; k++) begin
      e = exp_q.pop_front(); n_vec++;
      if (rout(k) !== e) begin n_err++; $display("FAIL midrun_r%0d: got %0d expected %0d", k, rout(k), e); end
    end
    @(negedge clk); rst = 1'b1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(32'd0);
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      e = exp_q.pop_front(); n_vec++;
      if (rout(k) !== e) begin n_err++; $display("FAIL midrst_r%0d: got %0d expected %0d", k, rout(k), e); end
    end
    n_vec++;
    if (dut.pc !== 10'd0) begin n_err++; $display("FAIL midrst_pc: got %0d expected 0", dut.pc); end
    n_vec++;
    if (dut.imem[0] !== enc(ADDI, 1, 0, 16'd11)) begin n_err++; $display("FAIL midrst_imem0: got %h", dut.imem[0]); end
    n_vec++;
    if (dut.dmem[200] !== 32'h0000_ABCD) begin n_err++; $display("FAIL midrst_dmem200: got %h expected 0000abcd", dut.dmem[200]); end
    run(1);
    n_vec++;
    if (dut.pc !== 10'd1) begin n_err++; $display("FAIL restart_pc: got %0d expected 1", dut.pc); end
    n_vec++;
    if (r1 !== 32'd11 || r2 !== 32'd0) begin n_err++; $display("FAIL restart_regs: got r1=%0d r2=%0d expected 11 0", r1, r2); end
  endtask

  initial begin
    test_reset();
    test_sort();
    test_addi_sext();
    test_load_store();
    test_branch();
    test_load_gating();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
